// File: rtl/rtc_pkg.sv
// rtc_pkg: command codes, FSM encoding, step counts and time-word layout for the RTC sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rtc_pkg;

  // Write command codes, in the order a set transaction issues them.
  localparam logic [7:0] CMD_WR_UNPROT = 8'h80;
  localparam logic [7:0] CMD_WR_YEAR   = 8'h15;
  localparam logic [7:0] CMD_WR_MONTH  = 8'h14;
  localparam logic [7:0] CMD_WR_DATE   = 8'h13;
  localparam logic [7:0] CMD_WR_HOUR   = 8'h12;
  localparam logic [7:0] CMD_WR_MINUTE = 8'h11;
  localparam logic [7:0] CMD_WR_SECOND = 8'h10;
  localparam logic [7:0] CMD_WR_PROT   = 8'h08;

  // Read command codes, in the order a read transaction issues them.
  localparam logic [7:0] CMD_RD_SECOND = 8'h01;
  localparam logic [7:0] CMD_RD_MINUTE = 8'h02;
  localparam logic [7:0] CMD_RD_HOUR   = 8'h03;
  localparam logic [7:0] CMD_RD_DATE   = 8'h04;
  localparam logic [7:0] CMD_RD_MONTH  = 8'h05;
  localparam logic [7:0] CMD_RD_YEAR   = 8'h06;

  // Payloads of the write-protect control commands.
  localparam logic [7:0] DAT_UNPROT = 8'h00;
  localparam logic [7:0] DAT_PROT   = 8'h80;

  localparam int SET_STEPS = 8;
  localparam int RD_STEPS  = 6;

  // Bit offsets of each BCD field in the 48-bit time word.
  localparam int OFS_SECOND = 0;
  localparam int OFS_MINUTE = 8;
  localparam int OFS_HOUR   = 16;
  localparam int OFS_DATE   = 24;
  localparam int OFS_MONTH  = 32;
  localparam int OFS_YEAR   = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } state_t;

  function automatic logic [7:0] set_code(input logic [2:0] step);
    logic [7:0] c;
    case (step)
      3'd0:    c = CMD_WR_UNPROT;
      3'd1:    c = CMD_WR_YEAR;
      3'd2:    c = CMD_WR_MONTH;
      3'd3:    c = CMD_WR_DATE;
      3'd4:    c = CMD_WR_HOUR;
      3'd5:    c = CMD_WR_MINUTE;
      3'd6:    c = CMD_WR_SECOND;
      default: c = CMD_WR_PROT;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] set_byte(input logic [2:0] step, input logic [47:0] t);
    logic [7:0] b;
    case (step)
      3'd0:    b = DAT_UNPROT;
      3'd1:    b = t[OFS_YEAR   +: 8];
      3'd2:    b = t[OFS_MONTH  +: 8];
      3'd3:    b = t[OFS_DATE   +: 8];
      3'd4:    b = t[OFS_HOUR   +: 8];
      3'd5:    b = t[OFS_MINUTE +: 8];
      3'd6:    b = t[OFS_SECOND +: 8];
      default: b = DAT_PROT;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] rd_code(input logic [2:0] step);
    logic [7:0] c;
    case (step)
      3'd0:    c = CMD_RD_SECOND;
      3'd1:    c = CMD_RD_MINUTE;
      3'd2:    c = CMD_RD_HOUR;
      3'd3:    c = CMD_RD_DATE;
      3'd4:    c = CMD_RD_MONTH;
      default: c = CMD_RD_YEAR;
    endcase
    return c;
  endfunction

  function automatic int rd_ofs(input logic [2:0] step);
    int o;
    case (step)
      3'd0:    o = OFS_SECOND;
      3'd1:    o = OFS_MINUTE;
      3'd2:    o = OFS_HOUR;
      3'd3:    o = OFS_DATE;
      3'd4:    o = OFS_MONTH;
      default: o = OFS_YEAR;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rtc_period_timer.sv
// rtc_period_timer: free-running counter that emits a 1-cycle tick every READ_PERIOD cycles (never when READ_PERIOD is 0).
// Latency: first tick READ_PERIOD cycles after reset release, then every READ_PERIOD cycles.
// Backpressure: none; free-runs regardless of downstream state, ticks are never held.
module rtc_period_timer
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD = 50_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  output logic tick
);

  if (READ_PERIOD == 0) begin : g_off
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RSTn;
    assign tick = 1'b0;
  end else begin : g_on
    localparam logic [31:0] CNT_LAST = 32'(READ_PERIOD - 1);
    logic [31:0] cnt;

    // Count 0..READ_PERIOD-1 and wrap.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)                cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                      cnt <= cnt + 32'd1;
    end

    assign tick = (cnt == CNT_LAST);
  end

endmodule

// File: rtl/rtc_sequencer.sv
// rtc_sequencer: runs complete RTC set/read transactions through the command block and publishes a coherent BCD time snapshot.
// Latency: first command code appears on the 2nd edge after a request is sampled; each command costs ISSUE + block time + one GAP.
// Backpressure: requests latch into pending flags while Busy; the command block paces steps via Cmd_Done_Sig, with a timeout abort.
module rtc_sequencer
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD = 50_000_000,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Set_Req,
  input  logic [47:0] Set_Time,
  input  logic        Read_Req,
  output logic [47:0] Time_Now,
  output logic        Time_Valid,
  output logic        Set_Done,
  output logic        Error,
  output logic        Busy,
  output logic [7:0]  Cmd_Start_Sig,
  output logic [7:0]  Cmd_Write_Data,
  input  logic        Cmd_Done_Sig,
  input  logic [7:0]  Cmd_Read_Data
);

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [2:0]  step;
  logic        is_set;
  logic [31:0] wait_cnt;
  logic        set_pend, rd_pend;
  logic [47:0] set_shadow;   // last requested set time
  logic [47:0] wr_time;      // frozen copy used by the running set
  logic [47:0] rd_shadow;    // bytes gathered by the running read
  logic        per_tick;

  logic        start_txn, take_set, enter_issue, done_hit, timeout_hit, last_step;
  logic [2:0]  issue_step;
  logic        issue_set;

  rtc_period_timer #(
    .READ_PERIOD(READ_PERIOD)
  ) u_period (
    .CLK (CLK),
    .RSTn(RSTn),
    .tick(per_tick)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the strobes that steer the datapath this cycle.
  always_comb begin
    state_nxt   = state;
    start_txn   = 1'b0;
    take_set    = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    last_step   = is_set ? (step == 3'(SET_STEPS - 1)) : (step == 3'(RD_STEPS - 1));
    case (state)
      ST_IDLE: begin
        if (set_pend || rd_pend) begin
          state_nxt = ST_ISSUE;
          start_txn = 1'b1;
          take_set  = set_pend;   // sets win over reads
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (Cmd_Done_Sig) begin
          done_hit  = 1'b1;
          state_nxt = ST_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_GAP:    state_nxt = last_step ? ST_FINISH : ST_ISSUE;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    enter_issue = (state_nxt == ST_ISSUE);
    issue_set   = start_txn ? take_set : is_set;
    issue_step  = start_txn ? 3'd0 : step + 3'd1;
  end

  // Pending flags, shadow registers, step index and wait counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      set_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      set_shadow <= '0;
      wr_time    <= '0;
      rd_shadow  <= '0;
      step       <= '0;
      is_set     <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (Set_Req) set_shadow <= Set_Time;
      // A request arriving on the cycle its flag is consumed stays pending.
      set_pend <= Set_Req | (set_pend & ~(start_txn & take_set));
      rd_pend  <= Read_Req | per_tick | (rd_pend & ~(start_txn & ~take_set));
      if (start_txn) wr_time <= set_shadow;
      if (enter_issue) begin
        step     <= issue_step;
        is_set   <= issue_set;
        wait_cnt <= '0;
      end else if ((state == ST_WAIT) && !done_hit) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if (done_hit && !is_set) rd_shadow[rd_ofs(step) +: 8] <= Cmd_Read_Data;
    end
  end

  // Registered outputs: command bus, status pulses, published time.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Cmd_Start_Sig  <= '0;
      Cmd_Write_Data <= '0;
      Time_Now       <= '0;
      Time_Valid     <= 1'b0;
      Set_Done       <= 1'b0;
      Error          <= 1'b0;
      Busy           <= 1'b0;
    end else begin
      Time_Valid <= 1'b0;
      Set_Done   <= 1'b0;
      Error      <= timeout_hit;
      Busy       <= (state_nxt != ST_IDLE);
      if (enter_issue) begin
        Cmd_Start_Sig  <= issue_set ? set_code(issue_step) : rd_code(issue_step);
        Cmd_Write_Data <= issue_set ? set_byte(issue_step, wr_time) : 8'h00;
      end else if (done_hit || timeout_hit) begin
        Cmd_Start_Sig  <= '0;
        Cmd_Write_Data <= '0;
      end
      if (state == ST_FINISH) begin
        if (is_set) begin
          Set_Done <= 1'b1;
        end else begin
          Time_Now   <= rd_shadow;
          Time_Valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_sequencer.sv
module tb_rtc_sequencer;

  localparam int TMO = 50;
  localparam int PER = 100;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTn, Set_Req, Read_Req, Cmd_Done_Sig;
  logic [47:0] Set_Time;
  logic [7:0]  Cmd_Read_Data;
  logic [47:0] Time_Now;
  logic        Time_Valid, Set_Done, Error, Busy;
  logic [7:0]  Cmd_Start_Sig, Cmd_Write_Data;

  logic        rstn_p, done_p, tv_p, sd_p, err_p, busy_p;
  logic [47:0] time_p;
  logic [7:0]  start_p, wdata_p;

  rtc_sequencer #(.READ_PERIOD(0), .TIMEOUT(TMO)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .Set_Req(Set_Req), .Set_Time(Set_Time), .Read_Req(Read_Req),
    .Time_Now(Time_Now), .Time_Valid(Time_Valid), .Set_Done(Set_Done), .Error(Error), .Busy(Busy),
    .Cmd_Start_Sig(Cmd_Start_Sig), .Cmd_Write_Data(Cmd_Write_Data),
    .Cmd_Done_Sig(Cmd_Done_Sig), .Cmd_Read_Data(Cmd_Read_Data));

  rtc_sequencer #(.READ_PERIOD(PER), .TIMEOUT(1000)) u_per (
    .CLK(CLK), .RSTn(rstn_p), .Set_Req(1'b0), .Set_Time(48'h0), .Read_Req(1'b0),
    .Time_Now(time_p), .Time_Valid(tv_p), .Set_Done(sd_p), .Error(err_p), .Busy(busy_p),
    .Cmd_Start_Sig(start_p), .Cmd_Write_Data(wdata_p),
    .Cmd_Done_Sig(done_p), .Cmd_Read_Data(8'h00));

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: expected commands {code,data}, completion kinds (0 set, 1 read, 2 error), read times.
  logic [15:0] exp_cmd[$];
  int          exp_kind[$];
  logic [47:0] exp_time[$];

  // Reference RTC register file (device) and the bench's prediction of its content.
  logic [7:0]  rtc[6];
  logic        wp;
  logic [7:0]  pred[6];
  logic [47:0] last_rd;
  bit          hang;
  bit          per_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rbcd(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [47:0] rand_time();
    return {rbcd(0, 99), rbcd(1, 12), rbcd(1, 31), rbcd(0, 23), rbcd(0, 59), rbcd(0, 59)};
  endfunction

  function automatic logic [47:0] pred_word();
    return {pred[5], pred[4], pred[3], pred[2], pred[1], pred[0]};
  endfunction

  task automatic push_read();
    for (int f = 0; f < 6; f++) exp_cmd.push_back({8'(f + 1), 8'h00});
    exp_kind.push_back(1);
    exp_time.push_back(pred_word());
    last_rd = pred_word();
  endtask

  task automatic push_set(input logic [47:0] t);
    exp_cmd.push_back({8'h80, 8'h00});
    for (int f = 5; f >= 0; f--) exp_cmd.push_back({8'(8'h10 + f), t[f*8 +: 8]});
    exp_cmd.push_back({8'h08, 8'h80});
    exp_kind.push_back(0);
    for (int f = 0; f < 6; f++) pred[f] = t[f*8 +: 8];
  endtask

  task automatic pulse(input bit s, input bit r, input logic [47:0] t);
    @(negedge CLK);
    Set_Req = s; Read_Req = r;
    if (s) Set_Time = t;
    @(negedge CLK);
    Set_Req = 1'b0; Read_Req = 1'b0;
    Set_Time = 48'({$urandom(), $urandom()});
  endtask

  task automatic flush();
    exp_cmd.delete(); exp_kind.delete(); exp_time.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_kind.size() != 0 || Busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
      flush();
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_time_now"}, Time_Now, 48'h0);
    check({tag, "_time_valid"}, Time_Valid, 0);
    check({tag, "_set_done"}, Set_Done, 0);
    check({tag, "_error"}, Error, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_cmd_start"}, Cmd_Start_Sig, 0);
    check({tag, "_cmd_wdata"}, Cmd_Write_Data, 0);
  endtask

  task automatic see_evt(input int kind, input string name);
    int k;
    logic [47:0] t;
    if (exp_kind.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got unexpected pulse, expected none", name);
    end else begin
      k = exp_kind.pop_front();
      check(name, kind, k);
      if (k == 1) begin
        t = exp_time.pop_front();
        if (kind == 1) check("time_now", Time_Now, t);
      end
    end
  endtask

  // Command-block / RTC device model: answers each command after 1..4 cycles.
  initial begin
    int   dly;
    bit   armed, served;
    int   code;
    Cmd_Done_Sig = 1'b0; Cmd_Read_Data = 8'h00;
    armed = 0; served = 0; dly = 0;
    forever begin
      @(negedge CLK);
      Cmd_Done_Sig = 1'b0;
      if (!RSTn || Cmd_Start_Sig == 8'h00) begin
        armed = 0; served = 0;
        continue;
      end
      if (served || hang) continue;
      if (!armed) begin
        armed = 1; dly = int'($urandom_range(3, 0));
      end else if (dly > 0) begin
        dly--;
      end else begin
        armed = 0; served = 1; Cmd_Done_Sig = 1'b1;
        code = int'(Cmd_Start_Sig);
        if (code >= 1 && code <= 6)        Cmd_Read_Data = rtc[code - 1];
        else if (code == 'h80 || code == 'h08) wp = Cmd_Write_Data[7];
        else if (code >= 'h10 && code <= 'h15 && !wp) rtc[code - 'h10] = Cmd_Write_Data;
      end
    end
  end

  // Monitor: compares every command issue and completion pulse against the queues.
  initial begin
    logic [7:0]  prev_start;
    logic [15:0] e;
    int          gap_run;
    bit          in_txn;
    prev_start = 0; gap_run = 0; in_txn = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_start = 0; gap_run = 0; in_txn = 0;
        continue;
      end
      if (Cmd_Start_Sig != 0 && prev_start == 0) begin
        if (in_txn) check("gap_cycles", gap_run, 1);
        if (exp_cmd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cmd_unexpected: got code %0h, expected no command", Cmd_Start_Sig);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_code", Cmd_Start_Sig, e[15:8]);
          if (e[15:8] >= 8'h08) check("cmd_data", Cmd_Write_Data, e[7:0]);
        end
        in_txn = 1;
      end
      if (Cmd_Start_Sig == 0 && Busy) gap_run++;
      else gap_run = 0;
      if (Set_Done)   see_evt(0, "evt_set_done");
      if (Time_Valid) see_evt(1, "evt_time_valid");
      if (Error)      see_evt(2, "evt_error");
      if (!Busy) in_txn = 0;
      prev_start = Cmd_Start_Sig;
    end
  end

  // Periodic-read instance: its command block answers one cycle late; reads must start every PER cycles.
  initial begin
    done_p = 1'b0;
    forever begin
      @(negedge CLK);
      if (done_p) done_p = 1'b0;
      else if (start_p != 0) done_p = 1'b1;
    end
  end

  initial begin
    int cyc, last, nint, ntv;
    bit prev_b;
    cyc = 0; last = -1; nint = 0; ntv = 0; prev_b = 0; per_done = 0;
    rstn_p = 1'b0;
    repeat (3) @(negedge CLK);
    rstn_p = 1'b1;
    while (nint < 5 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (busy_p && !prev_b) begin
        if (last >= 0) begin
          check("period_interval", cyc - last, PER);
          nint++;
        end
        last = cyc;
      end
      if (tv_p) ntv++;
      if (err_p) check("period_error", err_p, 0);
      prev_b = busy_p;
    end
    check("period_intervals_seen", nint, 5);
    check("period_reads_done", ntv, nint);
    per_done = 1;
  end

  // Stimulus.
  initial begin
    logic [47:0] t;
    int          n, op;
    bit          found;
    RSTn = 1'b0; Set_Req = 1'b0; Read_Req = 1'b0; Set_Time = 48'h0;
    hang = 0; wp = 1'b1; last_rd = 48'h0;
    for (int f = 0; f < 6; f++) begin rtc[f] = 8'h00; pred[f] = 8'h00; end
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed read with known device content.
    rtc[0] = 8'h45; rtc[1] = 8'h30; rtc[2] = 8'h12; rtc[3] = 8'h25; rtc[4] = 8'h06; rtc[5] = 8'h24;
    for (int f = 0; f < 6; f++) pred[f] = rtc[f];
    push_read();
    pulse(0, 1, 48'h0);
    wait_idle("read1");
    check("read1_time", Time_Now, 48'h24_06_25_12_30_45);

    // Directed set, then a read-back.
    push_set(48'h25_01_31_23_59_58);
    pulse(1, 0, 48'h25_01_31_23_59_58);
    wait_idle("set1");
    push_read();
    pulse(0, 1, 48'h0);
    wait_idle("set1_readback");
    check("set1_readback_time", Time_Now, 48'h25_01_31_23_59_58);

    // Set and read in the same cycle: set first.
    t = rand_time();
    push_set(t); push_read();
    pulse(1, 1, t);
    wait_idle("set_read_same");

    // Read requested in the middle of a set.
    t = rand_time();
    push_set(t); push_read();
    pulse(1, 0, t);
    repeat (10) @(negedge CLK);
    pulse(0, 1, 48'h0);
    wait_idle("read_during_set");

    // Timeout: device never answers.
    hang = 1;
    exp_cmd.push_back({8'h01, 8'h00});
    exp_kind.push_back(2);
    pulse(0, 1, 48'h0);
    n = 0;
    while (Cmd_Start_Sig == 0 && n < 20) begin @(negedge CLK); n++; end
    n = 0;
    while (Cmd_Start_Sig != 0 && n < 200) begin @(negedge CLK); n++; end
    check("timeout_start_cycles", n, TMO + 1);
    wait_idle("timeout");
    check("timeout_time_kept", Time_Now, last_rd);
    check("timeout_busy", Busy, 0);
    hang = 0;

    // Asynchronous reset during read step 3.
    push_read();
    pulse(0, 1, 48'h0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge CLK);
      if (Cmd_Start_Sig == 8'h04) found = 1;
    end
    check("reset_step3_reached", found, 1);
    #2 RSTn = 1'b0;
    #1 check_zero("midreset");
    flush();
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    push_read();
    pulse(0, 1, 48'h0);
    wait_idle("read_after_reset");

    // Randomized mix; device time occasionally moves between transactions.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        t = rand_time();
        for (int f = 0; f < 6; f++) begin rtc[f] = t[f*8 +: 8]; pred[f] = t[f*8 +: 8]; end
      end
      op = int'($urandom_range(3, 0));
      t = rand_time();
      case (op)
        0: begin push_read(); pulse(0, 1, t); end
        1: begin push_set(t); pulse(1, 0, t); end
        2: begin push_set(t); push_read(); pulse(1, 1, t); end
        default: begin
          push_set(t); push_read();
          pulse(1, 0, t);
          repeat (int'($urandom_range(25, 3))) @(negedge CLK);
          pulse(0, 1, 48'h0);
        end
      endcase
      wait_idle("random");
    end

    n = 0;
    while (!per_done && n < 3000) begin @(negedge CLK); n++; end
    check("period_check_finished", per_done, 1);
    check("leftover_cmds", exp_cmd.size(), 0);
    check("leftover_events", exp_kind.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
